// File: rtl/rag_pkg.sv
// rag_pkg: shared FSM state type and default widths for the read-address generator
package rag_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_PASS_W = 4;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
endpackage

// File: rtl/read_addr_gen_multi_if.sv
// read_addr_gen_multi_if: control/config inputs and address/status outputs; slave = generator, master = driver
interface read_addr_gen_multi_if
  import rag_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int PASS_W = DEF_PASS_W
);
  logic inner_rst;
  logic start;
  logic can_count;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_stride;
  logic [LEN_W-1:0] cfg_len;
  logic [PASS_W-1:0] cfg_passes;
  logic [ADDR_W-1:0] addr;
  logic load_registers;
  logic busy;
  logic pass_end;
  logic done;
  modport slave (
    input inner_rst, start, can_count, cfg_base, cfg_stride, cfg_len, cfg_passes,
    output addr, load_registers, busy, pass_end, done
  );
  modport master (
    output inner_rst, start, can_count, cfg_base, cfg_stride, cfg_len, cfg_passes,
    input addr, load_registers, busy, pass_end, done
  );
endinterface

// File: rtl/rag_counter.sv
// rag_counter: up-counter (i_clr > i_load > i_en priority) with o_tc high when o_cnt equals i_tc_val
module rag_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= i_clr ? '0 : i_load ? i_load_val : i_en ? r_cnt + W'(1) : r_cnt;
  assign o_cnt = r_cnt;
  assign o_tc = r_cnt == i_tc_val;
endmodule

// File: rtl/read_addr_gen_multi.sv
// read_addr_gen_multi: clk/rst plus bus (slave) emitting cfg_len strided addresses for cfg_passes passes, gated by can_count
module read_addr_gen_multi
  import rag_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int PASS_W = DEF_PASS_W
) (
  input logic clk,
  input logic rst,
  read_addr_gen_multi_if.slave bus
);
  state_t r_state;
  logic [ADDR_W-1:0] r_addr, r_base, r_stride;
  logic [LEN_W-1:0] r_len, w_idx;
  logic [PASS_W-1:0] r_passes, w_pass;
  logic w_abort, w_launch, w_consume, w_last, w_last_pass;
  assign w_abort = rst | bus.inner_rst;
  assign w_launch = r_state == IDLE && bus.start;
  assign w_consume = r_state == ACTIVE && bus.can_count;
  rag_counter #(.W(LEN_W)) u_idx (
    .clk(clk),
    .i_clr(w_abort | w_launch | (w_consume & w_last)),
    .i_load(1'b0),
    .i_load_val('0),
    .i_en(w_consume),
    .i_tc_val(r_len - LEN_W'(1)),
    .o_cnt(w_idx),
    .o_tc(w_last)
  );
  rag_counter #(.W(PASS_W)) u_pass (
    .clk(clk),
    .i_clr(w_abort | w_launch),
    .i_load(1'b0),
    .i_load_val('0),
    .i_en(w_consume & w_last & ~w_last_pass),
    .i_tc_val(r_passes - PASS_W'(1)),
    .o_cnt(w_pass),
    .o_tc(w_last_pass)
  );
  always_ff @(posedge clk) begin
    if (w_abort) begin
      r_state <= IDLE;
      r_addr <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          if (bus.cfg_len != '0) begin
            r_base <= bus.cfg_base;
            r_stride <= bus.cfg_stride;
            r_len <= bus.cfg_len;
            r_passes <= bus.cfg_passes == '0 ? PASS_W'(1) : bus.cfg_passes;
            r_addr <= bus.cfg_base;
            r_state <= ACTIVE;
          end else r_state <= DONE;
        end
        ACTIVE: if (bus.can_count) begin
          r_addr <= w_last ? r_base : r_addr + r_stride;
          if (w_last && w_last_pass) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.addr = r_addr;
  assign bus.load_registers = w_consume;
  assign bus.busy = r_state == ACTIVE;
  assign bus.pass_end = w_consume & w_last;
  assign bus.done = r_state == DONE;
endmodule

// File: tb/tb_read_addr_gen_multi.sv
// tb_read_addr_gen_multi: randomized scenarios checked against an element-queue reference model
module tb_read_addr_gen_multi;
  typedef struct {logic [7:0] a; logic last;} elem_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  read_addr_gen_multi_if bus();
  read_addr_gen_multi dut (.clk(clk), .rst(rst), .bus(bus));
  elem_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic done_pend = 0;
  logic [7:0] m_addr = 0;
  logic [11:0] exp_v;
  logic [11:0] obs;
  assign obs = {bus.addr, bus.load_registers, bus.busy, bus.pass_end, bus.done};
  task automatic launch(input logic [7:0] b, input logic [7:0] s, input logic [7:0] l, input logic [3:0] p);
    int np;
    @(negedge clk);
    bus.start = 1;
    bus.can_count = 0;
    bus.cfg_base = b;
    bus.cfg_stride = s;
    bus.cfg_len = l;
    bus.cfg_passes = p;
    np = (p == 0) ? 1 : int'(p);
    for (int k = 0; k < np; k++)
      for (int i = 0; i < int'(l); i++) q.push_back('{8'(int'(b) + i * int'(s)), i == int'(l) - 1});
    done_pend = 1;
    if (l != 0) m_addr = b;
  endtask
  task automatic step(input logic cc);
    @(negedge clk);
    bus.start = 0;
    bus.inner_rst = 0;
    rst = 0;
    bus.can_count = cc;
    #1;
    if (q.size() > 0) begin
      exp_v = {q[0].a, cc, 1'b1, cc & q[0].last, 1'b0};
      if (cc) void'(q.pop_front());
    end else if (done_pend) begin
      exp_v = {m_addr, 4'b0001};
      done_pend = 0;
    end else exp_v = {m_addr, 4'b0000};
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst = 1;
    bus.start = 1;
    bus.cfg_len = 4;
    @(negedge clk);
    rst = 1;
    bus.start = 1;
    for (int k = 0; k < 3; k++) begin
      step(k[0]);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL reset cyc%0d got %h exp %h", k, obs, exp_v); end
    end
  endtask
  task automatic test_basic;
    launch(8'h10, 8'h01, 8'd4, 4'd1);
    for (int k = 0; k < 8; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL basic cyc%0d got %h exp %h", k, obs, exp_v); end
    end
  endtask
  task automatic test_wrap;
    launch(8'hFC, 8'h02, 8'd4, 4'd1);
    for (int k = 0; k < 7; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL wrap cyc%0d got %h exp %h", k, obs, exp_v); end
    end
  endtask
  task automatic test_multi_stall;
    int n_pe, n_done;
    n_pe = 0;
    n_done = 0;
    launch(8'h20, 8'h01, 8'd3, 4'd2);
    for (int k = 0; k < 16; k++) begin
      step(~k[0]);
      n_pe += int'(bus.pass_end);
      n_done += int'(bus.done);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL stall cyc%0d got %h exp %h", k, obs, exp_v); end
    end
    n_cmp++;
    if (n_pe !== 2) begin n_err++; $display("FAIL stall_pass_end_count got %0d exp 2", n_pe); end
    n_cmp++;
    if (n_done !== 1) begin n_err++; $display("FAIL stall_done_count got %0d exp 1", n_done); end
  endtask
  task automatic test_degenerate;
    launch(8'h30, 8'h01, 8'd0, 4'd3);
    for (int k = 0; k < 3; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL len0 cyc%0d got %h exp %h", k, obs, exp_v); end
    end
    launch(8'h50, 8'h01, 8'd2, 4'd0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL passes0 cyc%0d got %h exp %h", k, obs, exp_v); end
    end
  endtask
  task automatic test_abort;
    launch(8'h60, 8'h01, 8'd8, 4'd1);
    for (int k = 0; k < 3; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL abort_pre cyc%0d got %h exp %h", k, obs, exp_v); end
    end
    bus.inner_rst = 1;
    q.delete();
    done_pend = 0;
    m_addr = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL abort_post cyc%0d got %h exp %h", k, obs, exp_v); end
    end
    launch(8'h70, 8'h05, 8'd3, 4'd2);
    for (int k = 0; k < 9; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL abort_rerun cyc%0d got %h exp %h", k, obs, exp_v); end
    end
  endtask
  task automatic test_ignored;
    launch(8'h80, 8'h03, 8'd5, 4'd3);
    for (int k = 0; k < 120 && (q.size() > 0 || done_pend); k++) begin
      step($urandom_range(0, 3) != 0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL ignored cyc%0d got %h exp %h", k, obs, exp_v); end
      bus.start = 1;
      bus.cfg_base = 8'($urandom);
      bus.cfg_len = 8'($urandom_range(1, 9));
    end
    step(1);
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL ignored_idle got %h exp %h", obs, exp_v); end
  endtask
  task automatic test_back_to_back;
    launch(8'h90, 8'h01, 8'd2, 4'd1);
    for (int k = 0; k < 10 && (q.size() > 0 || done_pend); k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL b2b_a cyc%0d got %h exp %h", k, obs, exp_v); end
    end
    launch(8'hA0, 8'h02, 8'd2, 4'd2);
    for (int k = 0; k < 7; k++) begin
      step(1);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL b2b_b cyc%0d got %h exp %h", k, obs, exp_v); end
    end
  endtask
  task automatic test_random;
    for (int r = 0; r < 10; r++) begin
      launch(8'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), 4'($urandom_range(0, 3)));
      for (int k = 0; k < 200 && (q.size() > 0 || done_pend); k++) begin
        step($urandom_range(0, 2) != 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL random run%0d cyc%0d got %h exp %h", r, k, obs, exp_v); end
      end
    end
  endtask
  initial begin
    bus.inner_rst = 0;
    bus.start = 0;
    bus.can_count = 0;
    bus.cfg_base = 0;
    bus.cfg_stride = 0;
    bus.cfg_len = 0;
    bus.cfg_passes = 0;
    test_reset;
    test_basic;
    test_wrap;
    test_multi_stall;
    test_degenerate;
    test_abort;
    test_ignored;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
